i2c_bus_frontend: RTL and testbench
===================================

Name: i2c_bus_frontend

Overview:
Input conditioning stage that sits directly upstream of the I2C slave on the bidirectional pins.
- Synchronises raw SCL/SDA pad inputs into the clk domain and rejects short glitches.
- Produces clean filtered levels, one-cycle SCL edge strobes, START/STOP detect strobes, a bus-busy flag and an SCL stuck-low timeout.
- The slave consumes these strobes instead of re-sampling raw pins.

Parameters:
SYNC_STAGES, 2, synchroniser flops per line (minimum 2)
FILT_LEN, 3, consecutive stable synced cycles required before a filtered level changes (minimum 1)
TIMEOUT_CYC, 4096, cycles SCL may stay low while busy before timeout fires (power of two ≤ 2^16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; low = hold at reset state, synchronously
scl_in  in  1  raw SCL pad input
sda_in  in  1  raw SDA pad input
scl_o  out  1  filtered SCL level
sda_o  out  1  filtered SDA level
scl_rise  out  1  one-cycle strobe, filtered SCL 0->1
scl_fall  out  1  one-cycle strobe, filtered SCL 1->0
start_det  out  1  one-cycle strobe, START or repeated START
stop_det  out  1  one-cycle strobe, STOP
bus_busy  out  1  high between START and STOP/timeout
bus_timeout  out  1  one-cycle strobe, SCL held low ≥ TIMEOUT_CYC while busy

Behaviour:
Reset (rst_n low, asynchronous):
- All synchroniser flops, scl_o, sda_o and the delayed copies reset to 1 (idle bus).
- Filter counters, timeout counter and bus_busy reset to 0.
- All strobes are 0.

ena low:
- Same values as reset are loaded on each clk edge.
- Outputs are held at reset values.

Synchroniser:
- SYNC_STAGES-deep flop chain per line, reset to 1.

Glitch filter (per line):
- Keep a counter cnt (width clog2(FILT_LEN+1)).
- If the synced level equals the filtered level: cnt <= 0.
- Otherwise, cnt increments. On the edge where cnt would reach FILT_LEN, the filtered level takes the synced value and cnt <= 0.
- A level change held steadily on the pin appears on scl_o/sda_o at the (SYNC_STAGES+FILT_LEN)-th rising edge, counting the first edge that samples it as edge 1. Default: edge 5.
- Synced pulses shorter than FILT_LEN cycles are fully rejected, with no output change.

Edge and condition detect:
- scl_q and sda_q are one-cycle delayed copies of scl_o and sda_o.
- scl_rise = scl_o & ~scl_q.
- scl_fall = ~scl_o & scl_q.
- start_det = scl_o & scl_q & sda_q & ~sda_o.
- stop_det = scl_o & scl_q & ~sda_q & sda_o.
- Each strobe is high exactly in the first cycle the new filtered level is visible.
- SCL and SDA changing in the same cycle is neither START nor STOP (SCL must be high in both cycles). The scl_rise/scl_fall strobe still fires.

bus_busy:
- Set the edge after start_det.
- Cleared the edge after stop_det or bus_timeout.
- A repeated START while busy keeps it high.
- STOP while idle has no effect on bus_busy. The stop_det strobe still fires.

Timeout:
- 16-bit counter tcnt. It increments while bus_busy & ~scl_o and clears otherwise.
- When tcnt reaches TIMEOUT_CYC-1 with the condition still true: bus_timeout pulses for 1 cycle, bus_busy clears, tcnt <= 0.
- No further timeouts fire until the next START.

Reset mid-transfer:
- All state returns to idle immediately.
- No strobe is generated on reset release.
- Filtered levels then track the pins with normal latency.

Decomposition:
- Package i2c_fe_pkg holds the default constants (SYNC_STAGES_DEF, FILT_LEN_DEF, TIMEOUT_CYC_DEF) and the idle level constant BUS_IDLE = 1'b1.
- Sub-module i2c_glitch_filter (synchroniser plus counter filter, parameters SYNC_STAGES and FILT_LEN, ports clk/rst_n/ena/d/q) is instantiated once for SCL and once for SDA.
- Edge and condition detect, busy and timeout logic stay in the top module.

Test Plan:
- Reset, then hold scl_in=sda_in=1 for 20 cycles -> scl_o=sda_o=1, all strobes 0, bus_busy=0.
- Default params, drop sda_in at edge 1 with scl_in=1 -> sda_o falls and start_det=1 at edge 5 for exactly 1 cycle; bus_busy=1 from edge 6; then raise sda_in -> stop_det 1 cycle, bus_busy=0.
- Pulse scl_in low for 2 cycles -> no change on scl_o, no strobe. Pulse low for 3 cycles -> scl_fall then scl_rise, each 1 cycle, 3 cycles apart.
- Change scl_in and sda_in on the same edge while SCL high -> scl_fall only, no start_det/stop_det.
- TIMEOUT_CYC=16: START, then hold scl_in low -> bus_timeout after 16 low filtered cycles, bus_busy=0, no second timeout.
- Assert rst_n low mid-byte with bus_busy=1 -> outputs idle immediately; release with pins high -> no strobes.

Source files
------------

// File: rtl/i2c_fe_pkg.sv
// Shared constants for the I2C bus front end: default parameter values and
// the idle (released) bus level.
package i2c_fe_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_LEN_DEF    = 3;
  localparam int TIMEOUT_CYC_DEF = 4096;

  localparam logic BUS_IDLE = 1'b1;

endpackage

// File: rtl/i2c_glitch_filter.sv
// Synchroniser chain followed by a consecutive-sample glitch filter for one
// open-drain bus line; idles high.
module i2c_glitch_filter
  import i2c_fe_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic d,
  output logic q
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= {SYNC_STAGES{BUS_IDLE}};
    end else if (!ena) begin
      sync <= {SYNC_STAGES{BUS_IDLE}};
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  // The filtered level only moves once the synced level has disagreed with it
  // for FILT_LEN consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q   <= BUS_IDLE;
      cnt <= '0;
    end else if (!ena) begin
      q   <= BUS_IDLE;
      cnt <= '0;
    end else if (synced == q) begin
      cnt <= '0;
    end else if (cnt == CNT_W'(FILT_LEN - 1)) begin
      q   <= synced;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bus_frontend.sv
// I2C pin conditioning: filtered SCL/SDA, edge strobes, START/STOP detect,
// bus-busy tracking and an SCL stuck-low timeout.
module i2c_bus_frontend
  import i2c_fe_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_o,
  output logic sda_o,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic bus_busy,
  output logic bus_timeout
);

  logic        scl_q;
  logic        sda_q;
  logic [15:0] tcnt;
  logic        scl_held_low;

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_scl_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .d    (scl_in),
    .q    (scl_o)
  );

  i2c_glitch_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_sda_filt (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .d    (sda_in),
    .q    (sda_o)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= BUS_IDLE;
      sda_q <= BUS_IDLE;
    end else if (!ena) begin
      scl_q <= BUS_IDLE;
      sda_q <= BUS_IDLE;
    end else begin
      scl_q <= scl_o;
      sda_q <= sda_o;
    end
  end

  // START/STOP need SCL high on both sides of the SDA change, so a
  // simultaneous SCL+SDA transition only yields an SCL edge strobe.
  assign scl_rise  = scl_o & ~scl_q;
  assign scl_fall  = ~scl_o & scl_q;
  assign start_det = scl_o & scl_q & sda_q & ~sda_o;
  assign stop_det  = scl_o & scl_q & ~sda_q & sda_o;

  assign scl_held_low = bus_busy & ~scl_o;
  assign bus_timeout  = scl_held_low & (tcnt == 16'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_busy <= 1'b0;
      tcnt     <= '0;
    end else if (!ena) begin
      bus_busy <= 1'b0;
      tcnt     <= '0;
    end else begin
      if (start_det) begin
        bus_busy <= 1'b1;
      end else if (stop_det || bus_timeout) begin
        bus_busy <= 1'b0;
      end
      if (scl_held_low && !bus_timeout) begin
        tcnt <= tcnt + 16'd1;
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_bus_frontend.sv
// Directed self-checking bench for i2c_bus_frontend with a short timeout
// (TIMEOUT_CYC=16) and default synchroniser/filter depths.
module tb_i2c_bus_frontend;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic scl_in;
  logic sda_in;
  logic scl_o, sda_o, scl_rise, scl_fall, start_det, stop_det, bus_busy, bus_timeout;

  int checks = 0;
  int errors = 0;

  logic any_strb;
  logic any_to;
  logic any_scl_low;

  i2c_bus_frontend #(
    .SYNC_STAGES(2),
    .FILT_LEN   (3),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .scl_in     (scl_in),
    .sda_in     (sda_in),
    .scl_o      (scl_o),
    .sda_o      (sda_o),
    .scl_rise   (scl_rise),
    .scl_fall   (scl_fall),
    .start_det  (start_det),
    .stop_det   (stop_det),
    .bus_busy   (bus_busy),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Runs n cycles and reports whether any strobe, a timeout, or a low scl_o was seen.
  task automatic watch(input int n, output logic strb, output logic to, output logic scl_low);
    strb    = 1'b0;
    to      = 1'b0;
    scl_low = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      strb    = strb | scl_rise | scl_fall | start_det | stop_det | bus_timeout;
      to      = to | bus_timeout;
      scl_low = scl_low | ~scl_o;
    end
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    ena    = 1'b1;
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(3);
    check("rst_scl_o", scl_o, 1'b1);
    check("rst_sda_o", sda_o, 1'b1);
    check("rst_busy", bus_busy, 1'b0);
    check("rst_start", start_det, 1'b0);

    rst_n = 1'b1;
    watch(20, any_strb, any_to, any_scl_low);
    check("idle_no_strobe", any_strb, 1'b0);
    check("idle_scl_high", any_scl_low, 1'b0);
    check("idle_sda_o", sda_o, 1'b1);
    check("idle_busy", bus_busy, 1'b0);

    // START: SDA falls while SCL high, visible at edge 5.
    sda_in = 1'b0;
    tick(4);
    check("start_e4_sda_o", sda_o, 1'b1);
    check("start_e4_det", start_det, 1'b0);
    tick(1);
    check("start_e5_sda_o", sda_o, 1'b0);
    check("start_e5_det", start_det, 1'b1);
    check("start_e5_busy", bus_busy, 1'b0);
    tick(1);
    check("start_e6_det", start_det, 1'b0);
    check("start_e6_busy", bus_busy, 1'b1);

    // STOP: SDA rises while SCL high.
    sda_in = 1'b1;
    tick(4);
    check("stop_e4_det", stop_det, 1'b0);
    tick(1);
    check("stop_e5_det", stop_det, 1'b1);
    check("stop_e5_busy", bus_busy, 1'b1);
    tick(1);
    check("stop_e6_det", stop_det, 1'b0);
    check("stop_e6_busy", bus_busy, 1'b0);

    // Two-cycle SCL glitch is rejected.
    scl_in = 1'b0;
    tick(2);
    scl_in = 1'b1;
    watch(10, any_strb, any_to, any_scl_low);
    check("glitch2_no_strobe", any_strb, 1'b0);
    check("glitch2_scl_high", any_scl_low, 1'b0);

    // Three-cycle SCL pulse passes: fall at edge 5, rise at edge 8.
    scl_in = 1'b0;
    tick(3);
    scl_in = 1'b1;
    tick(1);
    check("pulse3_e4_fall", scl_fall, 1'b0);
    tick(1);
    check("pulse3_e5_fall", scl_fall, 1'b1);
    check("pulse3_e5_scl_o", scl_o, 1'b0);
    tick(1);
    check("pulse3_e6_fall", scl_fall, 1'b0);
    tick(1);
    check("pulse3_e7_rise", scl_rise, 1'b0);
    tick(1);
    check("pulse3_e8_rise", scl_rise, 1'b1);
    check("pulse3_e8_scl_o", scl_o, 1'b1);
    tick(1);
    check("pulse3_e9_rise", scl_rise, 1'b0);
    tick(4);

    // SCL and SDA fall together: scl_fall only, no START.
    scl_in = 1'b0;
    sda_in = 1'b0;
    tick(5);
    check("same_fall", scl_fall, 1'b1);
    check("same_no_start", start_det, 1'b0);
    check("same_no_stop", stop_det, 1'b0);
    check("same_sda_o", sda_o, 1'b0);
    tick(1);
    check("same_busy", bus_busy, 1'b0);
    sda_in = 1'b1;
    tick(6);
    scl_in = 1'b1;
    tick(6);

    // Timeout: START, then hold SCL low; fires after 16 low filtered cycles.
    sda_in = 1'b0;
    tick(6);
    check("to_busy_set", bus_busy, 1'b1);
    scl_in = 1'b0;
    tick(5);
    check("to_scl_low", scl_o, 1'b0);
    check("to_e5_timeout", bus_timeout, 1'b0);
    watch(14, any_strb, any_to, any_scl_low);
    check("to_early", any_to, 1'b0);
    tick(1);
    check("to_fire", bus_timeout, 1'b1);
    check("to_fire_busy", bus_busy, 1'b1);
    tick(1);
    check("to_after", bus_timeout, 1'b0);
    check("to_busy_clr", bus_busy, 1'b0);
    watch(40, any_strb, any_to, any_scl_low);
    check("to_no_second", any_to, 1'b0);

    // STOP while idle still strobes but busy stays low.
    scl_in = 1'b1;
    tick(6);
    sda_in = 1'b1;
    tick(5);
    check("idle_stop_det", stop_det, 1'b1);
    check("idle_stop_busy", bus_busy, 1'b0);
    tick(4);

    // Repeated START keeps busy set.
    sda_in = 1'b0;
    tick(6);
    scl_in = 1'b0;
    tick(6);
    sda_in = 1'b1;
    tick(6);
    scl_in = 1'b1;
    tick(6);
    check("rstart_pre_busy", bus_busy, 1'b1);
    sda_in = 1'b0;
    tick(5);
    check("rstart_det", start_det, 1'b1);
    tick(1);
    check("rstart_busy", bus_busy, 1'b1);

    // Reset mid-transfer with bus busy and SCL low.
    scl_in = 1'b0;
    tick(6);
    check("mid_busy", bus_busy, 1'b1);
    check("mid_scl_low", scl_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_scl_o", scl_o, 1'b1);
    check("mid_rst_sda_o", sda_o, 1'b1);
    check("mid_rst_busy", bus_busy, 1'b0);
    scl_in = 1'b1;
    sda_in = 1'b1;
    tick(2);
    rst_n = 1'b1;
    watch(10, any_strb, any_to, any_scl_low);
    check("mid_release_no_strobe", any_strb, 1'b0);
    check("mid_release_busy", bus_busy, 1'b0);

    // ena low clears busy and filtered levels synchronously.
    sda_in = 1'b0;
    tick(6);
    check("ena_pre_busy", bus_busy, 1'b1);
    ena = 1'b0;
    tick(1);
    check("ena_busy", bus_busy, 1'b0);
    check("ena_sda_o", sda_o, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
